neuro_pin_driver: RTL
=====================

# neuro_pin_driver

Host-side initiator for the neurocore pin protocol. Accepts command bytes over a valid/ready stream, queues them in a small FIFO, drives each one onto the core's dedicated input pins, and waits a fixed settle time. It then samples the core's dedicated output pins and returns the sampled byte as a valid/ready response. It sits on the board/FPGA harness side, facing the tile's `ui_in`/`uo_out`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, default 2: cycles the command is held on `pin_out` before `pin_in` is sampled; ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_data`  in  8  command byte.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `pin_out`  out  8  drives the core's `ui_in`.
- `pin_in`  in  8  from the core's `uo_out`; treated as already synchronous.
- `rsp_data`  out  8  sampled response byte.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_err`  out  1  response mismatch (see Configuration).
- `err_cnt`  out  8  saturating mismatch count (see Configuration).

## Operation
- Push: `cmd_valid && cmd_ready` writes `cmd_data` into the FIFO. Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is `$clog2(FIFO_DEPTH+1)` bits wide.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: `pin_out` = 8'h00. If FIFO non-empty: pop the head, register `pin_out` ← head, load `cnt` ← `SETTLE_CYCLES-1`, go to DRIVE.
- DRIVE: `pin_out` holds the command. If `cnt==0`: `rsp_data` ← `pin_in`, `rsp_valid` ← 1, go to RESP. Otherwise `cnt--`.
- RESP: `rsp_valid`, `rsp_data`, and `pin_out` are held stable. On `rsp_ready`: `rsp_valid` ← 0, `pin_out` ← 8'h00, go to IDLE.
- One command in flight at a time. The FIFO keeps accepting while the FSM is busy.
- Simultaneous push and pop: both occur and occupancy is unchanged. When full, `cmd_ready` = 0 even if a pop happens in the same cycle.
- Protocol contract: the core answers 8'hFF to command 8'h01 and 8'h03 to any other byte, including idle 8'h00.

## Timing
- Reset values: `cmd_ready` = 1, `pin_out` = 8'h00, `rsp_data` = 8'h00, `rsp_valid` = 0, `rsp_err` = 0, `err_cnt` = 0. On reset, the FIFO is emptied and the FSM goes to IDLE.
- Reset mid-operation (any state) aborts the in-flight command. Queued commands are discarded. There is no partial response.
- Latency: a command accepted at edge E0 appears on `pin_out` after E1. `rsp_valid` rises after edge E1+`SETTLE_CYCLES`. Minimum accept-to-response latency is `SETTLE_CYCLES+1` cycles.
- Back-to-back commands: `pin_out` returns to 8'h00 for exactly one cycle (IDLE) between commands, then the next command is driven.
- `pin_in` is sampled exactly once per command, on the last DRIVE cycle.

## Configuration
- `NEURO_RSP_CHECK_EN` defined:
  - Expected response = (cmd==8'h01) ? 8'hFF : 8'h03.
  - `rsp_err` is registered with `rsp_data` and is valid while `rsp_valid` is high.
  - `err_cnt` increments on each mismatching capture and saturates at 8'hFF. It is cleared only by `rst`.
- Not defined: `rsp_err` and `err_cnt` are tied to 0, and no comparison logic is built.

## Structure
- Package `neuro_pin_pkg` holds:
  - Constants `CMD_FIRE`=8'h01, `RSP_FIRE`=8'hFF, `RSP_IDLE`=8'h03, `PIN_IDLE`=8'h00.
  - FSM state typedef.
- Sub-module `neuro_cmd_fifo`: synchronous FIFO parameterised by depth, with `full`/`empty` outputs.

## Test plan
- Reset, then push 8'h01 with `rsp_ready`=1 and a model core attached → `pin_out`=8'h01 one cycle after accept; `rsp_data`=8'hFF and `rsp_valid` 3 cycles after accept; `rsp_err`=0.
- Push 8'h01, 8'h05, 8'h00 back-to-back → responses FF, 03, 03 in order; `pin_out` returns to 8'h00 for one cycle between each command.
- Hold `rsp_ready`=0 and push 6 commands (depth 4) → `cmd_ready` drops after 4 entries are queued behind the in-flight command; `rsp_valid`/`rsp_data`/`pin_out` stay stable; releasing `rsp_ready` drains all commands in order.
- With `NEURO_RSP_CHECK_EN`, force `pin_in`=8'h00 for command 8'h01 → `rsp_err`=1 and `err_cnt`=1. After 300 forced mismatches, `err_cnt`=8'hFF.
- Assert `rst` during DRIVE with 2 commands queued → next cycle `pin_out`=0, `rsp_valid`=0, `cmd_ready`=1; no response is ever emitted for the aborted or queued commands.
- `SETTLE_CYCLES`=1, and change `pin_in` on the cycle after sampling → the captured value is the pre-change byte; latency is 2 cycles.

Source files
------------

// File: rtl/neuro_pin_pkg.sv
// Shared constants, FSM state type and protocol helper for the neurocore pin driver.
// Response checking in the driver is enabled by defining NEURO_RSP_CHECK_EN.
package neuro_pin_pkg;

    localparam logic [7:0] CMD_FIRE = 8'h01;
    localparam logic [7:0] RSP_FIRE = 8'hFF;
    localparam logic [7:0] RSP_IDLE = 8'h03;
    localparam logic [7:0] PIN_IDLE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } state_t;

    // The core answers RSP_FIRE to CMD_FIRE and RSP_IDLE to every other byte.
    function automatic logic [7:0] expected_rsp(input logic [7:0] cmd);
        return (cmd == CMD_FIRE) ? RSP_FIRE : RSP_IDLE;
    endfunction

endpackage

// File: rtl/neuro_cmd_fifo.sv
// Synchronous byte FIFO for queued commands; DEPTH must be a power of two so the
// pointers wrap naturally. Push is ignored when full, pop is ignored when empty.
module neuro_cmd_fifo
    import neuro_pin_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the occupancy count keeps stale entries unread.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/neuro_pin_driver.sv
// Host-side initiator: queues command bytes, drives them on the core pins, waits
// SETTLE_CYCLES, then returns the sampled pins. Define NEURO_RSP_CHECK_EN for checking.
module neuro_pin_driver
    import neuro_pin_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] pin_out,
    input  logic [7:0] pin_in,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_err,
    output logic [7:0] err_cnt
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             capture;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    // Last DRIVE cycle: the only point where pin_in is sampled for a command.
    assign capture   = (state == ST_DRIVE) && (cnt == '0);

    neuro_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .data_in (cmd_data),
        .push    (cmd_valid),
        .pop     (fifo_pop),
        .data_out(fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pin_out   <= PIN_IDLE;
            rsp_data  <= 8'h00;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pin_out <= fifo_head;
                        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                        state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (capture) begin
                        rsp_data  <= pin_in;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        pin_out   <= PIN_IDLE;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NEURO_RSP_CHECK_EN
    logic mismatch;

    // pin_out still carries the command while it is being captured.
    assign mismatch = (pin_in != expected_rsp(pin_out));

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
            err_cnt <= 8'h00;
        end else if (capture) begin
            rsp_err <= mismatch;
            if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
    assign err_cnt = 8'h00;
`endif

endmodule
